// File: rtl/bist_fault_reporter.sv
// Receiver-side link BIST checker. It compares LFSR patterns, serialises the sticky fault mask back
// to the sender, then forwards masked mission data. Define BIST_FAULT_COUNT_EN to add err_count.
module bist_fault_reporter #(
  parameter int unsigned TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int          TEST_CASES    = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic [TEST_CHANNELS-1:0] output_channels,
  output logic                     ready,
  output logic                     failed,
  output logic [TEST_CHANNELS-1:0] fault_mask,
  output logic                     report_tx,
  output logic                     report_done
`ifdef BIST_FAULT_COUNT_EN
  ,
  output logic [15:0]              err_count
`endif
);

  localparam int unsigned FrameLen = TEST_CHANNELS + 2;
  localparam int unsigned IdxW     = $clog2(FrameLen);
  localparam int unsigned CntW     = $clog2(TEST_CASES + 1);

  if (TEST_CASES < 1) begin : g_bad_cases
    $error("bist_fault_reporter: TEST_CASES must be >= 1");
  end
  if (SEED == 32'h0) begin : g_bad_seed
    $error("bist_fault_reporter: SEED must be nonzero");
  end

  typedef enum logic [1:0] {StCheck, StReport, StDone} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              lfsr_q, lfsr_d;
  logic [CntW-1:0]          case_cnt_q, case_cnt_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [TEST_CHANNELS-1:0] mask_q, mask_d;
  logic [TEST_CHANNELS-1:0] out_q, out_d;
  logic [TEST_CHANNELS-1:0] expected;
  logic [TEST_CHANNELS-1:0] diff;
  logic [FrameLen-1:0]      frame;
  logic                     last_case;
  logic                     frame_last;

  // Channels above 31 reuse the LFSR bits, inverted on every odd 32-channel group.
  always_comb begin
    expected = '0;
    for (int i = 0; i < int'(TEST_CHANNELS); i++) begin
      expected[i] = lfsr_q[i % 32] ^ 1'(i / 32);
    end
  end

  assign diff       = input_channels ^ expected;
  assign last_case  = (case_cnt_q == CntW'(TEST_CASES - 1));
  assign frame_last = (idx_q == IdxW'(FrameLen - 1));
  assign frame      = {^mask_q, mask_q, 1'b1};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StCheck;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCheck:  if (last_case) state_d = StReport;
      StReport: if (frame_last) state_d = StDone;
      StDone:   state_d = StDone;
      default:  state_d = StCheck;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready       = 1'b0;
    report_tx   = 1'b0;
    report_done = 1'b0;
    unique case (state_q)
      StCheck: ;
      StReport: begin
        ready     = 1'b1;
        report_tx = frame[idx_q];
      end
      StDone: begin
        ready       = 1'b1;
        report_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    lfsr_d     = lfsr_q;
    case_cnt_d = case_cnt_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    out_d      = '0;
    if (state_q == StCheck) begin
      mask_d = mask_q | diff;
      lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      if (!last_case) case_cnt_d = case_cnt_q + 1'b1;
    end else begin
      out_d = input_channels & ~mask_q;
    end
    if (state_q == StReport && !frame_last) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= SEED;
      case_cnt_q <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      out_q      <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      case_cnt_q <= case_cnt_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
    end
  end

  assign fault_mask      = mask_q;
  assign failed          = |mask_q;
  assign output_channels = out_q;

`ifdef BIST_FAULT_COUNT_EN
  logic [15:0] err_q, err_d;
  logic [16:0] pop;
  logic [16:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(TEST_CHANNELS); i++) begin
      pop = pop + 17'(diff[i]);
    end
    sum   = 17'(err_q) + pop;
    err_d = err_q;
    if (state_q == StCheck) err_d = sum[16] ? 16'hffff : sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_bist_fault_reporter.sv
// Directed bench for bist_fault_reporter: a time-indexed reference model checked every cycle, plus
// literal expectations at the interesting points of each scenario.
module tb_bist_fault_reporter;

  localparam int          N  = 70;
  localparam int          TC = 1000;
  localparam int          FL = N + 2;
  localparam logic [31:0] SD = 32'hdeadbeef;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_ch = '0;
  logic [N-1:0] output_channels;
  logic [N-1:0] fault_mask;
  logic         ready, failed, report_tx, report_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef BIST_FAULT_COUNT_EN
  logic [15:0] err_count;
  logic         sat_reset = 1'b1;
  logic [N-1:0] sat_in = '0;
  logic [N-1:0] sat_out, sat_mask;
  logic         sat_ready, sat_failed, sat_tx, sat_done;
  logic [15:0]  sat_err;

  bist_fault_reporter #(.TEST_CHANNELS(N), .SEED(SD), .TEST_CASES(2000)) u_sat (
    .clk             (clk),
    .reset           (sat_reset),
    .input_channels  (sat_in),
    .output_channels (sat_out),
    .ready           (sat_ready),
    .failed          (sat_failed),
    .fault_mask      (sat_mask),
    .report_tx       (sat_tx),
    .report_done     (sat_done),
    .err_count       (sat_err)
  );
`endif

  bist_fault_reporter #(.TEST_CHANNELS(N), .SEED(SD), .TEST_CASES(TC)) dut (
    .clk             (clk),
    .reset           (reset),
    .input_channels  (in_ch),
    .output_channels (output_channels),
    .ready           (ready),
    .failed          (failed),
    .fault_mask      (fault_mask),
    .report_tx       (report_tx),
`ifdef BIST_FAULT_COUNT_EN
    .report_done     (report_done),
    .err_count       (err_count)
`else
    .report_done     (report_done)
`endif
  );

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [N-1:0] pat(input logic [31:0] s);
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = s[i % 32] ^ (((i / 32) % 2) == 1);
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: everything is a function of m_t, the count of non-reset edges since reset.
  initial begin
    bit           m_valid;
    int           m_t, m_err, r;
    logic [31:0]  m_lfsr;
    logic [N-1:0] m_mask, m_out, d;
    logic         etx, rdy;
    m_valid = 0;
    m_t = 0;
    m_err = 0;
    m_lfsr = SD;
    m_mask = '0;
    m_out = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_valid = 1;
        m_t = 0;
        m_lfsr = SD;
        m_mask = '0;
        m_out = '0;
        m_err = 0;
      end else if (m_valid) begin
        m_out = (m_t >= TC) ? (in_ch & ~m_mask) : '0;
        if (m_t < TC) begin
          d = in_ch ^ pat(m_lfsr);
          m_mask = m_mask | d;
          m_err = m_err + $countones(d);
          if (m_err > 65535) m_err = 65535;
          m_lfsr = step(m_lfsr);
        end
        if (m_t < 1000000) m_t++;
      end
      #1;
      if (m_valid) begin
        rdy = (m_t >= TC);
        etx = 1'b0;
        if (m_t >= TC && m_t < TC + FL) begin
          r = m_t - TC;
          if (r == 0) etx = 1'b1;
          else if (r <= N) etx = m_mask[r-1];
          else etx = ^m_mask;
        end
        chk("ready", ready, rdy);
        chk("fault_mask", fault_mask, m_mask);
        if (rdy || m_t == 0) chk("failed", failed, |m_mask);
        chk("report_done", report_done, m_t >= TC + FL);
        chk("report_tx", report_tx, etx);
        chk("output_channels", output_channels, m_out);
`ifdef BIST_FAULT_COUNT_EN
        chk("err_count", err_count, m_err[15:0]);
`endif
      end
    end
  end

  // Sender-side stimulus state and fault injection controls.
  int           drv_k;
  logic [31:0]  drv_s;
  logic [N-1:0] f_hi, f_lo, f_inv, mission;
  int           f_invk;
  bit           rand_mission;

  task automatic cfg(input logic [N-1:0] hi, input logic [N-1:0] lo, input logic [N-1:0] inv,
                     input int invk, input bit rnd, input logic [N-1:0] mval);
    f_hi = hi;
    f_lo = lo;
    f_inv = inv;
    f_invk = invk;
    rand_mission = rnd;
    mission = mval;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_ch = '0;
    drv_k = 0;
    drv_s = SD;
  endtask

  task automatic feed(input int n);
    logic [N-1:0] v;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      reset = 1'b0;
      if (drv_k < TC) v = pat(drv_s);
      else if (rand_mission) v = N'({$urandom(), $urandom(), $urandom()});
      else v = mission;
      v = (v | f_hi) & ~f_lo;
      if (drv_k == f_invk) v = v ^ f_inv;
      in_ch = v;
      if (drv_k < TC) drv_s = step(drv_s);
      drv_k++;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] one;
    one = 1;
    cfg('0, '0, '0, -1, 1'b1, '0);

    // Reset state.
    do_reset();
    settle();
    chk("rst_ready", ready, 0);
    chk("rst_tx", report_tx, 0);
    chk("rst_done", report_done, 0);
    chk("rst_mask", fault_mask, 0);
    chk("rst_out", output_channels, 0);

    // Clean link: ready exactly TC edges after reset, 72-cycle frame.
    do_reset();
    feed(TC - 1);
    settle();
    chk("t1_ready_early", ready, 0);
    feed(1);
    settle();
    chk("t1_ready", ready, 1);
    chk("t1_start_bit", report_tx, 1);
    chk("t1_mask", fault_mask, 0);
    chk("t1_failed", failed, 0);
    feed(FL - 1);
    settle();
    chk("t1_done_early", report_done, 0);
    chk("t1_parity", report_tx, 0);
    feed(1);
    settle();
    chk("t1_done", report_done, 1);
    chk("t1_tx_idle", report_tx, 0);
    feed(20);

    // Channel 7 stuck high, channel 1 stuck low.
    cfg(one << 7, one << 1, '0, -1, 1'b0, 70'hcafecafe);
    do_reset();
    feed(TC);
    settle();
    chk("t2_mask", fault_mask, 70'h82);
    chk("t2_failed", failed, 1);
    feed(2);
    settle();
    chk("t2_frame_m1", report_tx, 1);
    feed(6);
    settle();
    chk("t2_frame_m7", report_tx, 1);
    feed(63);
    settle();
    chk("t2_parity", report_tx, 0);
    feed(2);
    settle();
    chk("t2_out", output_channels, 70'hcafeca7c);

    // Channel 69 flipped only on the last compare cycle.
    cfg('0, '0, one << 69, TC - 1, 1'b1, '0);
    do_reset();
    feed(TC);
    settle();
    chk("t3_mask", fault_mask, 70'h200000000000000000);
`ifdef BIST_FAULT_COUNT_EN
    chk("t3_err_count", err_count, 16'd1);
`endif
    feed(FL - 1);
    settle();
    chk("t3_parity", report_tx, 1);

    // Reset mid-check with channel 3 stuck low, then a clean rerun.
    cfg('0, one << 3, '0, -1, 1'b1, '0);
    do_reset();
    feed(500);
    settle();
    chk("t4_mask_before", fault_mask, 70'h8);
    do_reset();
    cfg('0, '0, '0, -1, 1'b1, '0);
    feed(TC - 1);
    settle();
    chk("t4_ready_early", ready, 0);
    chk("t4_mask_cleared", fault_mask, 0);
    feed(1);
    settle();
    chk("t4_ready", ready, 1);
    chk("t4_failed", failed, 0);

    // Reset in the tenth report cycle truncates the frame; a full rerun follows.
    do_reset();
    feed(TC);
    settle();
    feed(9);
    settle();
    do_reset();
    settle();
    chk("t5_tx_after_rst", report_tx, 0);
    chk("t5_ready_after_rst", ready, 0);
    feed(TC + FL);
    settle();
    chk("t5_done", report_done, 1);
    chk("t5_mask", fault_mask, 0);

`ifdef BIST_FAULT_COUNT_EN
    begin
      int          sum;
      logic [31:0] s;
      sum = 0;
      s = SD;
      for (int k = 0; k < TC; k++) begin
        sum += $countones(pat(s));
        s = step(s);
      end
      cfg('0, '1, '0, -1, 1'b1, '0);
      do_reset();
      feed(TC);
      settle();
      chk("t6_err_sum", err_count, sum[15:0]);

      s = SD;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        sat_reset = 1'b0;
        sat_in = ~pat(s);
        s = step(s);
      end
      settle();
      chk("t6_sat_ready", sat_ready, 1);
      chk("t6_sat_err", sat_err, 16'hffff);
      chk("t6_sat_mask", sat_mask, {N{1'b1}});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
